// File: rtl/hmm_pkg.sv
// Shared definitions for the HMM sequence generator: widths, FSM encoding,
// LFSR constants and the CDF threshold-select helper.
package hmm_pkg;
  localparam int          SW    = 2;
  localparam int          CDF_W = 16;
  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam logic [15:0] POLY  = 16'hB400;

  typedef logic [SW-1:0] sym_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PICK_S0, S_PICK_OBS, S_SEND, S_PICK_TRANS, S_DONE
  } fsm_t;

  // Inverse-CDF sample over three outcomes; a non-increasing cdf_1 simply
  // makes outcome 1 unreachable.
  function automatic sym_t cdf_sel(input logic [CDF_W-1:0] r,
                                   input logic [CDF_W-1:0] cdf_0,
                                   input logic [CDF_W-1:0] cdf_1);
    if (r <= cdf_0)      return 2'd0;
    else if (r <= cdf_1) return 2'd1;
    else                 return 2'd2;
  endfunction
endpackage

// File: rtl/hmm_lfsr.sv
// Right-shifting Galois LFSR with seed load (zero seed replaced by SEED0)
// and an advance enable so it only moves on draws.
module hmm_lfsr #(
  parameter int           W     = 16,
  parameter logic [W-1:0] POLY  = 16'hB400,
  parameter logic [W-1:0] SEED0 = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         adv,
  output logic [W-1:0] value
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= SEED0;
    else if (load) value <= (seed == '0) ? SEED0 : seed;
    else if (adv)  value <= {1'b0, value[W-1:1]} ^ (value[0] ? POLY : '0);
  end
endmodule

// File: rtl/hmm_seq_gen.sv
// Samples a hidden-state path and observation stream from a 3-state/3-symbol
// HMM and streams the symbols out with valid/ready, recording the true path.
module hmm_seq_gen
  import hmm_pkg::*;
#(
  parameter int           W      = CDF_W,
  parameter logic [W-1:0] POLY_P = POLY,
  parameter logic [W-1:0] SEED_P = SEED0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   length,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] cdfC_0,
  input  logic [W-1:0] cdfC_1,
  input  logic [W-1:0] cdfA_0_0,
  input  logic [W-1:0] cdfA_0_1,
  input  logic [W-1:0] cdfA_1_0,
  input  logic [W-1:0] cdfA_1_1,
  input  logic [W-1:0] cdfA_2_0,
  input  logic [W-1:0] cdfA_2_1,
  input  logic [W-1:0] cdfB_0_0,
  input  logic [W-1:0] cdfB_0_1,
  input  logic [W-1:0] cdfB_1_0,
  input  logic [W-1:0] cdfB_1_1,
  input  logic [W-1:0] cdfB_2_0,
  input  logic [W-1:0] cdfB_2_1,
  output logic [1:0]   obs_out,
  output logic         obs_valid,
  input  logic         obs_ready,
  output logic         obs_first,
  output logic         obs_last,
  output logic [1:0]   state_0,
  output logic [1:0]   state_1,
  output logic [1:0]   state_2,
  output logic [1:0]   state_3,
  output logic [1:0]   state_4,
  output logic [1:0]   state_5,
  output logic [1:0]   state_6,
  output logic [1:0]   state_7,
  output logic         busy,
  output logic         done
);
  fsm_t           st;
  sym_t           cur_s;
  logic [2:0]     cnt;
  logic [3:0]     len_q;
  logic [7:0][1:0] path;
  logic [W-1:0]   rnd, c0, c1;
  sym_t           draw;
  logic           lfsr_load, lfsr_adv;

  assign lfsr_load = (st == S_IDLE) && start && seed_load;
  assign lfsr_adv  = (st == S_PICK_S0) || (st == S_PICK_OBS) || (st == S_PICK_TRANS);

  hmm_lfsr #(.W(W), .POLY(POLY_P), .SEED0(SEED_P)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .adv   (lfsr_adv),
    .value (rnd)
  );

  // Threshold pair for whichever draw the current state performs.
  always_comb begin
    c0 = '0;
    c1 = '0;
    case (st)
      S_PICK_S0: begin c0 = cdfC_0; c1 = cdfC_1; end
      S_PICK_OBS:
        case (cur_s)
          2'd0:    begin c0 = cdfB_0_0; c1 = cdfB_0_1; end
          2'd1:    begin c0 = cdfB_1_0; c1 = cdfB_1_1; end
          default: begin c0 = cdfB_2_0; c1 = cdfB_2_1; end
        endcase
      S_PICK_TRANS:
        case (cur_s)
          2'd0:    begin c0 = cdfA_0_0; c1 = cdfA_0_1; end
          2'd1:    begin c0 = cdfA_1_0; c1 = cdfA_1_1; end
          default: begin c0 = cdfA_2_0; c1 = cdfA_2_1; end
        endcase
      default: ;
    endcase
  end

  assign draw = cdf_sel(rnd, c0, c1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      cur_s     <= '0;
      cnt       <= '0;
      len_q     <= '0;
      path      <= '0;
      obs_out   <= '0;
      obs_valid <= 1'b0;
      obs_first <= 1'b0;
      obs_last  <= 1'b0;
    end else begin
      case (st)
        S_IDLE:
          if (start) begin
            len_q <= (length == 3'd0) ? 4'd8 : {1'b0, length};
            cnt   <= '0;
            st    <= S_PICK_S0;
          end
        S_PICK_S0: begin
          cur_s <= draw;
          st    <= S_PICK_OBS;
        end
        S_PICK_OBS: begin
          obs_out    <= draw;
          path[cnt]  <= cur_s;
          obs_first  <= (cnt == 3'd0);
          obs_last   <= ({1'b0, cnt} == len_q - 4'd1);
          obs_valid  <= 1'b1;
          st         <= S_SEND;
        end
        S_SEND:
          if (obs_ready) begin
            obs_valid <= 1'b0;
            if (obs_last) st <= S_DONE;
            else begin
              cnt <= cnt + 3'd1;
              st  <= S_PICK_TRANS;
            end
          end
        S_PICK_TRANS: begin
          cur_s <= draw;
          st    <= S_PICK_OBS;
        end
        S_DONE:
          if (!start) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign busy = (st != S_IDLE) && (st != S_DONE);
  assign done = (st == S_DONE);

  assign state_0 = path[0];
  assign state_1 = path[1];
  assign state_2 = path[2];
  assign state_3 = path[3];
  assign state_4 = path[4];
  assign state_5 = path[5];
  assign state_6 = path[6];
  assign state_7 = path[7];
endmodule

// File: tb/tb_hmm_seq_gen.sv
// Directed bench for hmm_seq_gen: hand-computed forced-chain vectors plus an
// independent LFSR/sampling model for seeded, backpressure and reset runs.
module tb_hmm_seq_gen;
  logic        clk = 1'b0;
  logic        rst_n, start, seed_load, obs_ready;
  logic [2:0]  length;
  logic [15:0] seed;
  logic [15:0] cdfC_0, cdfC_1;
  logic [15:0] cdfA_0_0, cdfA_0_1, cdfA_1_0, cdfA_1_1, cdfA_2_0, cdfA_2_1;
  logic [15:0] cdfB_0_0, cdfB_0_1, cdfB_1_0, cdfB_1_1, cdfB_2_0, cdfB_2_1;
  logic [1:0]  obs_out;
  logic        obs_valid, obs_first, obs_last, busy, done;
  logic [1:0]  state_0, state_1, state_2, state_3, state_4, state_5, state_6, state_7;
  logic [1:0]  sp [8];

  always #5 clk = ~clk;

  hmm_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .seed_load(seed_load), .seed(seed),
    .cdfC_0(cdfC_0), .cdfC_1(cdfC_1),
    .cdfA_0_0(cdfA_0_0), .cdfA_0_1(cdfA_0_1), .cdfA_1_0(cdfA_1_0),
    .cdfA_1_1(cdfA_1_1), .cdfA_2_0(cdfA_2_0), .cdfA_2_1(cdfA_2_1),
    .cdfB_0_0(cdfB_0_0), .cdfB_0_1(cdfB_0_1), .cdfB_1_0(cdfB_1_0),
    .cdfB_1_1(cdfB_1_1), .cdfB_2_0(cdfB_2_0), .cdfB_2_1(cdfB_2_1),
    .obs_out(obs_out), .obs_valid(obs_valid), .obs_ready(obs_ready),
    .obs_first(obs_first), .obs_last(obs_last),
    .state_0(state_0), .state_1(state_1), .state_2(state_2), .state_3(state_3),
    .state_4(state_4), .state_5(state_5), .state_6(state_6), .state_7(state_7),
    .busy(busy), .done(done)
  );

  assign sp[0] = state_0; assign sp[1] = state_1;
  assign sp[2] = state_2; assign sp[3] = state_3;
  assign sp[4] = state_4; assign sp[5] = state_5;
  assign sp[6] = state_6; assign sp[7] = state_7;

  typedef struct {
    logic [15:0] c [2];
    logic [15:0] a [3][2];
    logic [15:0] b [3][2];
    logic [2:0]  len;
    logic [1:0]  obs [8];
    logic [1:0]  st [8];
  } vec_t;

  vec_t vecs [4];
  vec_t cur, rcfg;

  int checks = 0, errors = 0;

  logic [15:0] mlfsr;
  logic [1:0]  mobs [8];
  logic [1:0]  mst [8];
  int          mn;

  logic [1:0]  gobs [8];
  logic        gfirst [8], glast [8];
  int          gcyc [8];
  int          gn, stalls;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] r);
    return (r >> 1) ^ (r[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [1:0] msel(input logic [15:0] r, input logic [15:0] c0, input logic [15:0] c1);
    if (r <= c0) return 2'd0;
    if (r <= c1) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_run(input bit ld, input logic [15:0] sd);
    logic [1:0] s;
    mn = (cur.len == 3'd0) ? 8 : int'(cur.len);
    if (ld) mlfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    s = msel(mlfsr, cur.c[0], cur.c[1]);
    mlfsr = mstep(mlfsr);
    for (int k = 0; k < mn; k++) begin
      if (k > 0) begin
        s = msel(mlfsr, cur.a[s][0], cur.a[s][1]);
        mlfsr = mstep(mlfsr);
      end
      mobs[k] = msel(mlfsr, cur.b[s][0], cur.b[s][1]);
      mlfsr = mstep(mlfsr);
      mst[k] = s;
    end
  endtask

  task automatic drive_cfg();
    cdfC_0 = cur.c[0]; cdfC_1 = cur.c[1];
    cdfA_0_0 = cur.a[0][0]; cdfA_0_1 = cur.a[0][1];
    cdfA_1_0 = cur.a[1][0]; cdfA_1_1 = cur.a[1][1];
    cdfA_2_0 = cur.a[2][0]; cdfA_2_1 = cur.a[2][1];
    cdfB_0_0 = cur.b[0][0]; cdfB_0_1 = cur.b[0][1];
    cdfB_1_0 = cur.b[1][0]; cdfB_1_1 = cur.b[1][1];
    cdfB_2_0 = cur.b[2][0]; cdfB_2_1 = cur.b[2][1];
    length = cur.len;
  endtask

  // One full sequence; optional 4-cycle stall when symbol stall_at is offered.
  task automatic run(input bit ld, input logic [15:0] sd, input int stall_at);
    int cyc;
    logic [1:0] hold;
    drive_cfg();
    model_run(ld, sd);
    @(negedge clk); seed_load = ld; seed = sd; start = 1'b1;
    @(negedge clk); start = 1'b0; seed_load = 1'b0;
    gn = 0; cyc = 0; stalls = 0; hold = '0;
    while (gn < mn && cyc < 300) begin
      if (obs_valid) begin
        if (gn == stall_at && stalls < 4) begin
          if (stalls == 0) hold = obs_out;
          else chk("stall_obs_stable", obs_out, hold);
          obs_ready = 1'b0;
          stalls++;
        end else begin
          if (gn == stall_at) chk("stall_release_obs", obs_out, hold);
          obs_ready = 1'b1;
          gobs[gn] = obs_out; gfirst[gn] = obs_first; glast[gn] = obs_last;
          gcyc[gn] = cyc;
          gn++;
        end
      end else obs_ready = 1'b0;
      @(negedge clk); cyc++;
    end
    obs_ready = 1'b0;
    chk("accept_count", gn, mn);
    if (stall_at >= 0) chk("stall_cycles", stalls, 4);
    chk("done_after_last", done, 1);
    chk("busy_in_done", busy, 0);
    for (int k = 0; k < gn; k++) begin
      chk("obs_first", gfirst[k], (k == 0) ? 1 : 0);
      chk("obs_last", glast[k], (k == mn - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk("idle_after_done", done, 0);
  endtask

  task automatic cmp_model();
    for (int k = 0; k < mn; k++) chk("model_obs", gobs[k], mobs[k]);
    for (int k = 0; k < 8; k++)  chk("model_state", sp[k], mst[k]);
  endtask

  initial begin
    // Forced chain 1->2->0->1..., obs mirrors state.
    vecs[0].c = '{16'h0000, 16'hFFFF};
    vecs[0].a = '{'{16'h0000, 16'hFFFF}, '{16'h0000, 16'h0000}, '{16'hFFFF, 16'hFFFF}};
    vecs[0].b = '{'{16'hFFFF, 16'hFFFF}, '{16'h0000, 16'hFFFF}, '{16'h0000, 16'h0000}};
    vecs[0].len = 3'd5;
    vecs[0].obs = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    vecs[0].st  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    // Same chain, length 0 = 8 symbols.
    vecs[1] = vecs[0];
    vecs[1].len = 3'd0;
    vecs[1].obs = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    vecs[1].st  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    // cdf_0=cdf_1=0 forces outcome 2; stuck in state 2 emitting 0; upper states kept.
    vecs[2] = vecs[0];
    vecs[2].c = '{16'h0000, 16'h0000};
    vecs[2].a[2] = '{16'h0000, 16'h0000};
    vecs[2].b[2] = '{16'hFFFF, 16'hFFFF};
    vecs[2].len = 3'd3;
    vecs[2].obs = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[2].st  = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    // 0<->1 alternation, emissions 2/1.
    vecs[3].c = '{16'hFFFF, 16'hFFFF};
    vecs[3].a = '{'{16'h0000, 16'hFFFF}, '{16'hFFFF, 16'hFFFF}, '{16'hFFFF, 16'hFFFF}};
    vecs[3].b = '{'{16'h0000, 16'h0000}, '{16'h0000, 16'hFFFF}, '{16'hFFFF, 16'hFFFF}};
    vecs[3].len = 3'd4;
    vecs[3].obs = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[3].st  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    rcfg.c = '{16'h5555, 16'hAAAA};
    rcfg.a = '{'{16'h4000, 16'hC000}, '{16'h8000, 16'h9000}, '{16'h2000, 16'h6000}};
    rcfg.b = '{'{16'h6000, 16'hA000}, '{16'h3000, 16'hF000}, '{16'h9000, 16'hD000}};
    rcfg.len = 3'd6;
    rcfg.obs = '{default: 2'd0};
    rcfg.st  = '{default: 2'd0};

    mlfsr = 16'hACE1;
    mst = '{default: 2'd0};
    rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed = '0; obs_ready = 1'b0;
    cur = vecs[0]; drive_cfg();
    repeat (2) @(negedge clk);
    chk("rst_obs_valid", obs_valid, 0);
    chk("rst_obs_out", obs_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_first_last", {obs_first, obs_last}, 0);
    chk("rst_state_0", state_0, 0);
    chk("rst_state_7", state_7, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      cur = vecs[v];
      run(1'b0, 16'h0, -1);
      for (int k = 0; k < mn; k++) chk("vec_obs", gobs[k], cur.obs[k]);
      for (int k = 0; k < 8; k++)  chk("vec_state", sp[k], cur.st[k]);
      for (int k = 1; k < gn; k++) chk("throughput", gcyc[k] - gcyc[k-1], 3);
    end

    // Backpressure on symbol 2: same chain output, LFSR must not move while stalled.
    cur = vecs[0];
    run(1'b0, 16'h0, 2);
    for (int k = 0; k < mn; k++) chk("bp_obs", gobs[k], cur.obs[k]);
    cur = rcfg;
    run(1'b0, 16'h0, 3);
    cmp_model();
    run(1'b0, 16'h0, -1);
    cmp_model();

    // Seeding: explicit seed twice, zero seed, then free-running continuation.
    run(1'b1, 16'd1234, -1); cmp_model();
    run(1'b1, 16'd1234, -1); cmp_model();
    run(1'b1, 16'h0000, -1); cmp_model();
    run(1'b0, 16'h5A5A, -1); cmp_model();

    // Reset after the second accept.
    begin
      int acc, cyc;
      @(negedge clk); seed_load = 1'b1; seed = 16'd1234; start = 1'b1;
      @(negedge clk); start = 1'b0; seed_load = 1'b0;
      acc = 0; cyc = 0;
      while (acc < 2 && cyc < 100) begin
        obs_ready = obs_valid;
        if (obs_valid) acc++;
        @(negedge clk); cyc++;
      end
      chk("pre_reset_accepts", acc, 2);
      chk("pre_reset_busy", busy, 1);
      obs_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", obs_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_obs_out", obs_out, 0);
      chk("mid_rst_state_0", state_0, 0);
      chk("mid_rst_state_1", state_1, 0);
      @(negedge clk); rst_n = 1'b1;
      mlfsr = 16'hACE1;
      mst = '{default: 2'd0};
      run(1'b0, 16'h0, -1);
      cmp_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
